// File: rtl/move_sequencer.sv
// move_sequencer
//   Move queue and dispatcher between the solver and the motor move controller.
//   Packed move words are unpacked (one slot per cycle, zero codes skipped)
//   into a linear queue that appends across loads. The queue is then
//   dispatched one move at a time over a start_move/move_done handshake,
//   with pause, abort, overflow detection and run-time status.
//
// Ports
//   clock, reset_n          system clock, asynchronous active-low reset
//   load, seq, load_ready   append request, packed moves (first in MSBs), accept
//   run, pause, abort       start dispatch, hold at move boundary, flush queue
//   next_move, start_move   move code and its one-cycle valid strobe
//   move_done               completion pulse from the move controller
//   busy                    not idle
//   seq_done, seq_aborted   one-cycle completion / abort pulses
//   overflow                sticky: a nonzero move was dropped on a full queue
//   num_moves, curr_step    queued move count, index of next move to dispatch
module move_sequencer #(
   parameter int MOVE_W    = 4,
   parameter int SEQ_MOVES = 50,
   parameter int DEPTH     = 64,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        load,
   input  logic [SEQ_MOVES*MOVE_W-1:0] seq,
   output logic                        load_ready,
   input  logic                        run,
   input  logic                        pause,
   input  logic                        abort,
   output logic [MOVE_W-1:0]           next_move,
   output logic                        start_move,
   input  logic                        move_done,
   output logic                        busy,
   output logic                        seq_done,
   output logic                        seq_aborted,
   output logic                        overflow,
   output logic [CNT_W-1:0]            num_moves,
   output logic [CNT_W-1:0]            curr_step
);

   localparam int SEQ_W = SEQ_MOVES * MOVE_W;
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      IDLE, UNPACK, LOAD_MOVE, WAIT_1, WAIT_2, PAUSED, FINISH, ABORT
   } state_t;

   state_t            state;
   logic [SEQ_W-1:0]  shreg;
   logic              abort_pend;
   logic [MOVE_W-1:0] queue [DEPTH];

   logic [MOVE_W-1:0] head;
   logic [SEQ_W-1:0]  shnext;
   logic              head_nz;
   logic              rest_zero;
   logic              q_full;
   logic              q_wr;

   assign head      = shreg[SEQ_W-1 -: MOVE_W];
   assign shnext    = shreg << MOVE_W;
   assign head_nz   = |head;
   // Leave UNPACK as soon as nothing nonzero remains, so trailing zero slots cost no cycles.
   assign rest_zero = (shnext == '0);
   assign q_full    = (num_moves == DEPTH_C);
   assign q_wr      = (state == UNPACK) && head_nz && !q_full;

   assign load_ready = (state == IDLE);
   assign busy       = (state != IDLE);

   // Queue storage carries no reset; its contents are only meaningful below num_moves.
   always_ff @(posedge clock) begin
      if (q_wr)
         queue[num_moves[IDX_W-1:0]] <= head;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         shreg       <= '0;
         abort_pend  <= 1'b0;
         next_move   <= '0;
         start_move  <= 1'b0;
         seq_done    <= 1'b0;
         seq_aborted <= 1'b0;
         overflow    <= 1'b0;
         num_moves   <= '0;
         curr_step   <= '0;
      end else begin
         start_move  <= 1'b0;
         seq_done    <= 1'b0;
         seq_aborted <= 1'b0;
         unique case (state)
            IDLE: begin
               if (abort)
                  state <= ABORT;
               else if (load) begin
                  shreg <= seq;
                  state <= UNPACK;
               end else if (run && (num_moves != '0))
                  state <= LOAD_MOVE;
            end
            UNPACK: begin
               if (abort)
                  state <= ABORT;
               else begin
                  if (head_nz) begin
                     if (!q_full)
                        num_moves <= num_moves + CNT_W'(1);
                     else
                        overflow <= 1'b1;
                  end
                  shreg <= shnext;
                  if (rest_zero)
                     state <= IDLE;
               end
            end
            LOAD_MOVE: begin
               next_move  <= queue[curr_step[IDX_W-1:0]];
               curr_step  <= curr_step + CNT_W'(1);
               start_move <= 1'b1;
               if (abort)
                  abort_pend <= 1'b1;
               state <= WAIT_1;
            end
            WAIT_1: begin
               // move_done is deliberately not observed here.
               if (abort)
                  abort_pend <= 1'b1;
               state <= WAIT_2;
            end
            WAIT_2: begin
               if (move_done) begin
                  // An abort arriving with move_done counts as pending and wins over pause.
                  if (abort_pend || abort) begin
                     abort_pend <= 1'b0;
                     state      <= ABORT;
                  end else if (curr_step == num_moves)
                     state <= FINISH;
                  else if (pause)
                     state <= PAUSED;
                  else
                     state <= LOAD_MOVE;
               end else if (abort)
                  abort_pend <= 1'b1;
            end
            PAUSED: begin
               if (abort)
                  state <= ABORT;
               else if (!pause)
                  state <= LOAD_MOVE;
            end
            FINISH: begin
               seq_done  <= 1'b1;
               curr_step <= '0;
               num_moves <= '0;
               next_move <= '0;
               state     <= IDLE;
            end
            ABORT: begin
               seq_aborted <= 1'b1;
               abort_pend  <= 1'b0;
               curr_step   <= '0;
               num_moves   <= '0;
               next_move   <= '0;
               overflow    <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
//   Bench for move_sequencer (DEPTH=4 so the queue fills easily). Stimulus
//   pushes expected dispatches and completion events into queues; a monitor
//   pops and compares whenever start_move, seq_done or seq_aborted appear.
//   The reference is a plain queue of move codes plus a sticky overflow bit.
module tb_move_sequencer;

   localparam int MW = 4;
   localparam int SM = 50;
   localparam int DP = 4;
   localparam int CW = $clog2(DP + 1);
   localparam int SW = SM * MW;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          load = 1'b0, run = 1'b0, pause = 1'b0, abort = 1'b0;
   logic          move_done = 1'b0;
   logic [SW-1:0] seq = '0;
   logic          load_ready, start_move, busy, seq_done, seq_aborted, overflow;
   logic [MW-1:0] next_move;
   logic [CW-1:0] num_moves, curr_step;

   move_sequencer #(.MOVE_W(MW), .SEQ_MOVES(SM), .DEPTH(DP)) dut (
      .clock(clock), .reset_n(reset_n), .load(load), .seq(seq),
      .load_ready(load_ready), .run(run), .pause(pause), .abort(abort),
      .next_move(next_move), .start_move(start_move), .move_done(move_done),
      .busy(busy), .seq_done(seq_done), .seq_aborted(seq_aborted),
      .overflow(overflow), .num_moves(num_moves), .curr_step(curr_step)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int mv;
      int step;
      bit gap;
   } exp_t;

   exp_t exp_q[$];
   int   evt_q[$];   // 1 = seq_done, 2 = seq_aborted
   int   mq[$];      // reference queue contents
   bit   m_ovf = 1'b0;
   int   last_done_cyc = -100;
   int   ctl_lo = 5, ctl_hi = 5;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [SW-1:0] put(input logic [SW-1:0] s, input int slot, input int m);
      s[(SM-1-slot)*MW +: MW] = MW'(m);
      return s;
   endfunction

   task automatic chk_reset(input string nm);
      check(nm, {load_ready, busy, start_move, seq_done, seq_aborted, overflow,
                 next_move, num_moves, curr_step},
            {1'b1, {(5 + MW + 2*CW){1'b0}}});
   endtask

   // Move controller: answers each start_move with a one-cycle move_done.
   initial begin
      int d;
      forever begin
         @(negedge clock);
         if (start_move && reset_n) begin
            d = $urandom_range(ctl_hi, ctl_lo);
            repeat (d - 1) @(negedge clock);
            last_done_cyc = cyc;
            move_done = 1'b1;
            @(negedge clock);
            move_done = 1'b0;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit   prev_start = 1'b0;
      exp_t e;
      int   code;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            if (start_move) begin
               check("start_width", prev_start, 0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_start: next_move=%0d, none expected", next_move);
               end else begin
                  e = exp_q.pop_front();
                  check("next_move", next_move, e.mv);
                  check("curr_step_at_start", curr_step, e.step);
                  if (e.gap)
                     check("done_to_start_gap", cyc - last_done_cyc, 2);
               end
            end
            if (seq_done || seq_aborted) begin
               code = seq_done ? (seq_aborted ? 3 : 1) : 2;
               if (evt_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event: code=%0d, none expected", code);
               end else
                  check("completion_event", code, evt_q.pop_front());
            end
         end
         prev_start = start_move;
      end
   end

   task automatic do_load(input logic [SW-1:0] s, input bit with_run);
      int last = -1;
      int expc;
      int n = 0;
      logic [MW-1:0] m;
      for (int i = 0; i < SM; i++) begin
         m = s[(SM-1-i)*MW +: MW];
         if (m != 0) begin
            last = i;
            if (mq.size() < DP) mq.push_back(int'(m));
            else m_ovf = 1'b1;
         end
      end
      expc = (last < 0) ? 1 : last + 1;
      @(negedge clock);
      load = 1'b1;
      run  = with_run;
      seq  = s;
      @(negedge clock);
      load = 1'b0;
      run  = 1'b0;
      check("load_ready_fall", load_ready, 0);
      while (!load_ready && n < 400) begin
         @(negedge clock);
         n++;
      end
      check("unpack_cycles", n, expc);
      check("num_moves_after_load", num_moves, mq.size());
      check("overflow_after_load", overflow, m_ovf);
   endtask

   task automatic run_seq(input int n_disp, input int no_gap, input int evt);
      for (int i = 0; i < n_disp; i++)
         exp_q.push_back('{mv: mq[i], step: i + 1, gap: (i > 0 && i != no_gap)});
      evt_q.push_back(evt);
      @(negedge clock);
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      check("run_busy", busy, 1);
      check("run_strobe_early", start_move, 0);
      @(negedge clock);
      check("run_first_strobe", start_move, 1);
   endtask

   task automatic wait_idle(input bit aborted);
      int n = 0;
      while (busy && n < 3000) begin
         @(negedge clock);
         n++;
      end
      check("idle_timeout", busy, 0);
      @(negedge clock);
      mq.delete();
      if (aborted) m_ovf = 1'b0;
      check("num_moves_cleared", num_moves, 0);
      check("curr_step_cleared", curr_step, 0);
      check("next_move_cleared", next_move, 0);
      check("overflow_after_end", overflow, m_ovf);
      check("moves_outstanding", exp_q.size(), 0);
      check("events_outstanding", evt_q.size(), 0);
   endtask

   task automatic async_reset(input string nm);
      #2 reset_n = 1'b0;
      #1 chk_reset(nm);
      exp_q.delete();
      evt_q.delete();
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (10) @(negedge clock);
   endtask

   initial begin
      logic [SW-1:0] s;
      int   L;
      bit   saw;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1 chk_reset("reset_async");
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk_reset("reset_released");

      // Simple sequence 3,7,1.
      s = '0; s = put(s, 0, 3); s = put(s, 1, 7); s = put(s, 2, 1);
      do_load(s, 1'b0);
      run_seq(3, -1, 1);
      wait_idle(1'b0);

      // Append with zero skip: 2,0,5 then 9.
      s = '0; s = put(s, 0, 2); s = put(s, 2, 5);
      do_load(s, 1'b0);
      s = '0; s = put(s, 0, 9);
      do_load(s, 1'b0);
      run_seq(3, -1, 1);
      wait_idle(1'b0);

      // Overflow: six moves into a four-deep queue; overflow survives seq_done.
      s = '0;
      for (int i = 0; i < 6; i++) s = put(s, i, i + 1);
      do_load(s, 1'b0);
      run_seq(4, -1, 1);
      wait_idle(1'b0);

      // Pause during move 1 of 3.
      s = '0; s = put(s, 0, 4); s = put(s, 1, 5); s = put(s, 2, 6);
      do_load(s, 1'b0);
      run_seq(3, 1, 1);
      pause = 1'b1;
      saw = 1'b0;
      repeat (12) begin
         @(negedge clock);
         if (start_move) saw = 1'b1;
      end
      check("pause_no_start", saw, 0);
      check("pause_busy", busy, 1);
      check("pause_curr_step", curr_step, 1);
      pause = 1'b0;
      @(negedge clock);
      check("pause_release_early", start_move, 0);
      @(negedge clock);
      check("pause_release_strobe", start_move, 1);
      wait_idle(1'b0);

      // Abort during WAIT_2 of move 2 of 4; also clears the sticky overflow.
      s = '0;
      for (int i = 0; i < 4; i++) s = put(s, i, 10 + i);
      do_load(s, 1'b0);
      run_seq(2, -1, 2);
      L = 0;
      do begin
         @(negedge clock);
         L++;
      end while (!start_move && L < 50);
      check("abort_second_start_seen", start_move, 1);
      @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      wait_idle(1'b1);

      // Async reset mid-UNPACK.
      s = '0;
      for (int i = 0; i < SM; i++) s = put(s, i, 1);
      @(negedge clock);
      load = 1'b1;
      seq  = s;
      @(negedge clock);
      load = 1'b0;
      repeat (3) @(negedge clock);
      async_reset("reset_mid_unpack");

      // Async reset mid-WAIT_2.
      s = '0; s = put(s, 0, 8); s = put(s, 1, 9); s = put(s, 2, 10);
      do_load(s, 1'b0);
      run_seq(3, -1, 1);
      @(negedge clock);
      async_reset("reset_mid_wait2");

      // Normal operation after reset; load and run together, load wins.
      s = '0; s = put(s, 0, 15); s = put(s, 3, 6);
      do_load(s, 1'b1);
      @(negedge clock);
      check("load_beats_run", busy, 0);
      run_seq(2, -1, 1);
      wait_idle(1'b0);

      // Run on an empty queue is ignored.
      @(negedge clock);
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      check("run_empty_ignored", busy, 0);

      // Randomized loads and runs with varying controller latency.
      ctl_lo = 6;
      ctl_hi = 2;
      for (int it = 0; it < 16; it++) begin
         for (int k = 0; k < int'($urandom_range(2, 1)); k++) begin
            s = '0;
            L = $urandom_range(10, 0);
            for (int j = 0; j <= L; j++)
               if ($urandom_range(1, 0) == 1) s = put(s, j, $urandom_range(15, 1));
            if ($urandom_range(4, 0) == 0) s = put(s, SM - 1, $urandom_range(15, 1));
            do_load(s, 1'b0);
         end
         if (mq.size() > 0) begin
            run_seq(mq.size(), -1, 1);
            wait_idle(1'b0);
         end else begin
            @(negedge clock);
            run = 1'b1;
            @(negedge clock);
            run = 1'b0;
            check("rand_run_empty", busy, 0);
         end
      end

      repeat (5) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

endmodule
